// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues
// one word fetch at a time over a req/ack memory handshake (variable latency,
// zero-wait allowed), and presents {instr, PC+4} to the IF/ID register.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous, active-high reset
//   hazard_i       IF/ID stall; buffered outputs must hold
//   redirect_i     one-cycle taken branch/jump
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   imem_req_o     fetch request
//   imem_addr_o    fetch word address (bits [1:0] always 00)
//   imem_ack_i     response valid (may coincide with the request cycle)
//   imem_rdata_i   instruction word, valid with imem_ack_i
//   if_instr_o     instruction to IF/ID (NOP_INSTR when no valid fetch)
//   if_newpc_o     PC+4 of if_instr_o (0 when no valid fetch)
//   if_valid_o     if_instr_o is a real fetch
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FETCH | request outstanding at pc_q (idle for one cycle after reset)
// S_FULL  | buf stalled and skid holds a captured word; no request
// S_DRAIN | waiting out a request abandoned by a redirect; data discarded
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        hazard_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_newpc_o,
   output logic        if_valid_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_FULL  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

   state_t      state_q;
   logic        req_q;
   logic [31:0] pc_q;
   logic [31:0] drain_q;
   logic [31:0] buf_instr_q;
   logic [31:0] buf_pc4_q;
   logic        buf_valid_q;
   logic [31:0] skid_instr_q;
   logic [31:0] skid_pc4_q;
   logic        skid_valid_q;

   logic        ack;
   logic        buf_free;
   logic [31:0] pc4_d;
   logic [31:0] target_d;

   // An ack only counts against a request we actually have on the bus.
   assign ack      = imem_ack_i & req_q;
   assign buf_free = ~buf_valid_q | ~hazard_i;
   assign pc4_d    = pc_q + 32'd4;
   assign target_d = redirect_pc_i & 32'hFFFF_FFFC;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_FETCH;
         req_q        <= 1'b0;
         pc_q         <= RESET_PC_W;
         drain_q      <= 32'd0;
         buf_instr_q  <= 32'd0;
         buf_pc4_q    <= 32'd0;
         buf_valid_q  <= 1'b0;
         skid_instr_q <= 32'd0;
         skid_pc4_q   <= 32'd0;
         skid_valid_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q         <= target_d;
         buf_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         req_q        <= 1'b1;
         unique case (state_q)
            S_FETCH: begin
               // A pending request that is not acked now must be waited out.
               if (req_q && !ack) begin
                  drain_q <= pc_q;
                  state_q <= S_DRAIN;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_FULL:  state_q <= S_FETCH;
            S_DRAIN: state_q <= ack ? S_FETCH : S_DRAIN;
            default: state_q <= S_FETCH;
         endcase
      end else begin
         unique case (state_q)
            S_FETCH: begin
               req_q <= 1'b1;
               if (ack) begin
                  pc_q <= pc4_d;
                  if (buf_free) begin
                     buf_instr_q <= imem_rdata_i;
                     buf_pc4_q   <= pc4_d;
                     buf_valid_q <= 1'b1;
                  end else begin
                     skid_instr_q <= imem_rdata_i;
                     skid_pc4_q   <= pc4_d;
                     skid_valid_q <= 1'b1;
                     req_q        <= 1'b0;
                     state_q      <= S_FULL;
                  end
               end else if (buf_free) begin
                  buf_valid_q <= 1'b0;
               end
            end
            S_FULL: begin
               if (!hazard_i) begin
                  buf_instr_q  <= skid_instr_q;
                  buf_pc4_q    <= skid_pc4_q;
                  buf_valid_q  <= skid_valid_q;
                  skid_valid_q <= 1'b0;
                  req_q        <= 1'b1;
                  state_q      <= S_FETCH;
               end
            end
            S_DRAIN: begin
               req_q <= 1'b1;
               if (!hazard_i) begin
                  buf_valid_q <= 1'b0;
               end
               if (ack) begin
                  state_q <= S_FETCH;
               end
            end
            default: begin
               req_q   <= 1'b1;
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = (state_q == S_DRAIN) ? drain_q : pc_q;
   assign if_valid_o  = buf_valid_q;
   assign if_instr_o  = buf_valid_q ? buf_instr_q : NOP_INSTR;
   assign if_newpc_o  = buf_valid_q ? buf_pc4_q : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scenarios followed by a randomized run. A behavioural memory
// (fixed or random latency) answers requests; the reference model is the
// program-order address stream: every instruction IF/ID accepts must be the
// next sequential address, restarting at the aligned target after a redirect,
// and must carry the word stored at that address.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        hazard;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [31:0] if_newpc;
   logic        if_valid;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .hazard_i      (hazard),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .if_instr_o    (if_instr),
      .if_newpc_o    (if_newpc),
      .if_valid_o    (if_valid)
   );

   int          compared   = 0;
   int          mismatched = 0;
   int          consumed   = 0;
   int          idle       = 0;
   bit          mem_busy   = 1'b0;
   int          mem_cnt    = 0;
   int          mem_lat    = 0;   // -1 selects random latency 0..2
   logic [31:0] mem_addr   = 32'd0;
   logic [31:0] exp_pc     = 32'd0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[31:2] ^ 30'h1696_9696, 2'b11};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      hazard      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      #1;
      chk1("rst_req",   imem_req, 1'b0);
      chk1("rst_valid", if_valid, 1'b0);
      chk ("rst_newpc", if_newpc, 32'd0);
      chk ("rst_instr", if_instr, NOP);
      @(negedge clk);
      @(negedge clk);
      reset    = 1'b0;
      mem_busy = 1'b0;
      exp_pc   = 32'd0;
      idle     = 0;
   endtask

   // One clock: memory answers, invariants checked, edge taken, model updated.
   task automatic cycle(input bit h, input bit r, input logic [31:0] rpc);
      logic        pv;
      logic [31:0] pn;
      logic [31:0] pi;
      bit          ack;
      hazard      = h;
      redirect    = r;
      redirect_pc = rpc;
      ack         = 1'b0;
      if (imem_req) begin
         chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
         end else begin
            chk("addr_stable", imem_addr, mem_addr);
         end
         ack = (mem_cnt == 0);
      end else if (mem_busy) begin
         chk1("req_withdrawn", imem_req, 1'b1);
         mem_busy = 1'b0;
      end
      imem_ack   = ack;
      imem_rdata = ack ? mem_data(mem_addr) : 32'hDEAD_BEEF;
      if (if_valid) begin
         chk("instr_match", if_instr, mem_data(if_newpc - 32'd4));
      end else begin
         chk("bubble_instr", if_instr, NOP);
         chk("bubble_newpc", if_newpc, 32'd0);
      end
      pv = if_valid;
      pn = if_newpc;
      pi = if_instr;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (ack) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (pv && !h) begin
         chk("stream_pc", pn - 32'd4, exp_pc);
         exp_pc = exp_pc + 32'd4;
         consumed++;
         idle = 0;
      end else begin
         idle++;
      end
      if (pv && h && !r) begin
         chk ("hold_newpc", if_newpc, pn);
         chk ("hold_instr", if_instr, pi);
         chk1("hold_valid", if_valid, 1'b1);
      end
      if (r) exp_pc = rpc & 32'hFFFF_FFFC;
      if (idle > 40) begin
         chk("progress_timeout", 32'(idle), 32'd0);
         idle = 0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Zero-wait memory: one instruction per cycle.
      mem_lat = 0;
      do_reset();
      chk1("t1_req_idle", imem_req, 1'b0);
      cycle(0, 0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk1("t1_req",  imem_req,  1'b1);
         chk ("t1_addr", imem_addr, 32'(4 * i));
         if (i > 0) begin
            chk ("t1_newpc", if_newpc, 32'(4 * i));
            chk1("t1_valid", if_valid, 1'b1);
         end
         cycle(0, 0, 32'd0);
      end

      // Three-cycle stall while buf holds the word at 4.
      do_reset();
      cycle(0, 0, 32'd0);
      cycle(0, 0, 32'd0);
      chk("t2_newpc_c2", if_newpc, 32'h4);
      cycle(0, 0, 32'd0);
      chk ("t2_newpc_c3", if_newpc, 32'h8);
      chk ("t2_addr_c3",  imem_addr, 32'h8);
      chk1("t2_req_c3",   imem_req, 1'b1);
      cycle(1, 0, 32'd0);
      chk1("t2_req_c4",   imem_req, 1'b0);
      chk ("t2_newpc_c4", if_newpc, 32'h8);
      cycle(1, 0, 32'd0);
      chk1("t2_req_c5",   imem_req, 1'b0);
      chk ("t2_newpc_c5", if_newpc, 32'h8);
      cycle(1, 0, 32'd0);
      chk ("t2_newpc_c6", if_newpc, 32'h8);
      cycle(0, 0, 32'd0);
      chk ("t2_newpc_c7", if_newpc, 32'hC);
      chk ("t2_addr_c7",  imem_addr, 32'hC);
      cycle(0, 0, 32'd0);
      chk ("t2_newpc_c8", if_newpc, 32'h10);

      // Two wait states, then a redirect while the fetch of 0x8 is pending.
      mem_lat = 2;
      do_reset();
      cycle(0, 0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk ("t3_addr_wait",  imem_addr, 32'h0);
         chk1("t3_valid_wait", if_valid, 1'b0);
         chk ("t3_instr_wait", if_instr, NOP);
         cycle(0, 0, 32'd0);
      end
      chk1("t3_valid_c4", if_valid, 1'b1);
      chk ("t3_newpc_c4", if_newpc, 32'h4);
      cycle(0, 0, 32'd0);
      chk1("t3_valid_c5", if_valid, 1'b0);
      cycle(0, 0, 32'd0);
      chk1("t3_valid_c6", if_valid, 1'b0);
      cycle(0, 0, 32'd0);
      chk ("t3_newpc_c7", if_newpc, 32'h8);
      chk ("t3_addr_c7",  imem_addr, 32'h8);
      cycle(0, 1, 32'h100);
      for (int i = 0; i < 2; i++) begin
         chk ("t3_drain_addr",  imem_addr, 32'h8);
         chk1("t3_drain_valid", if_valid, 1'b0);
         cycle(0, 0, 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         chk ("t3_target_addr",  imem_addr, 32'h100);
         chk1("t3_target_valid", if_valid, 1'b0);
         cycle(0, 0, 32'd0);
      end
      chk1("t3_valid_c13", if_valid, 1'b1);
      chk ("t3_newpc_c13", if_newpc, 32'h104);

      // Redirect while stalled with skid full, then a redirect to the top word.
      mem_lat = 0;
      do_reset();
      cycle(0, 0, 32'd0);
      cycle(0, 0, 32'd0);
      chk("t4_newpc_c2", if_newpc, 32'h4);
      cycle(1, 0, 32'd0);
      chk1("t4_req_full", imem_req, 1'b0);
      cycle(1, 1, 32'h200);
      chk1("t4_req_c4",   imem_req, 1'b1);
      chk ("t4_addr_c4",  imem_addr, 32'h200);
      chk1("t4_valid_c4", if_valid, 1'b0);
      cycle(0, 0, 32'd0);
      chk ("t4_newpc_c5", if_newpc, 32'h204);
      cycle(0, 1, 32'hFFFF_FFFE);
      chk ("t4_addr_top",  imem_addr, 32'hFFFF_FFFC);
      chk1("t4_valid_top", if_valid, 1'b0);
      cycle(0, 0, 32'd0);
      chk ("t4_addr_wrap",  imem_addr, 32'h0);
      chk ("t4_newpc_wrap", if_newpc, 32'h0);
      chk1("t4_valid_wrap", if_valid, 1'b1);
      chk ("t4_instr_wrap", if_instr, mem_data(32'hFFFF_FFFC));
      cycle(0, 0, 32'd0);
      chk ("t4_newpc_after", if_newpc, 32'h4);

      // Asynchronous reset in the middle of a wait with a valid word buffered.
      mem_lat = 2;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(0, 0, 32'd0);
      cycle(1, 0, 32'd0);
      chk1("t5_req_pre",   imem_req, 1'b1);
      chk1("t5_valid_pre", if_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk1("t5_req_async",   imem_req, 1'b0);
      chk1("t5_valid_async", if_valid, 1'b0);
      chk ("t5_newpc_async", if_newpc, 32'd0);
      chk ("t5_instr_async", if_instr, NOP);

      // Randomized latency, stalls and redirects against the stream model.
      mem_lat = -1;
      do_reset();
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         bit          h;
         bit          r;
         logic [31:0] t;
         h = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
         cycle(h, r, t);
      end
      chk1("rand_throughput", (consumed > 500), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches over a req/ack instruction-memory handshake that tolerates variable latency.
- Presents {instruction, PC+4} to IF/ID and honours the same hazard stall that freezes IF/ID.
- Redirects on branch/jump: flushes buffered fetches and discards any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word driven when no valid fetch is buffered (bubble).

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
hazard  in  1  stall from hazard unit; IF/ID holds and this block must hold its outputs.
redirect  in  1  one-cycle taken branch/jump request.
redirect_pc  in  32  target address; bits [1:0] ignored (forced 00).
imem_req  out  1  fetch request.
imem_addr  out  32  fetch word address; bits [1:0] always 00.
imem_ack  in  1  response valid; may be high in the same cycle as imem_req (zero-wait).
imem_rdata  in  32  instruction word, valid when imem_ack=1.
IF_instr  out  32  instruction to IF/ID.
IF_newPC  out  32  PC+4 of IF_instr, to IF/ID.
IF_valid  out  1  IF_instr is a real fetch, not a bubble.

Behaviour:
- Reset (async, takes effect immediately): pc=RESET_PC; state=FETCH; buf and skid invalid; IF_instr=NOP_INSTR; IF_newPC=0; IF_valid=0; imem_req=0 while reset is high. Reset mid-transaction abandons the request; memory shares the reset.
- Storage: buf {instr, pc4, valid} drives outputs. skid {instr, pc4, valid} catches a response that arrives while buf is stalled.
- Outputs: IF_instr=buf.valid?buf.instr:NOP_INSTR; IF_newPC=buf.valid?buf.pc4:0; IF_valid=buf.valid. All driven from registers only.
- buf is consumed at any edge with hazard=0 (IF/ID captures it). buf_free = !buf.valid || !hazard.
- Handshake: once imem_req=1, imem_req and imem_addr stay stable until an edge with imem_ack=1. Requests are never withdrawn except by reset.
- State FETCH: imem_req=1, imem_addr=pc.
  - ack & buf_free: buf<={rdata, pc+4, 1}; pc<=pc+4; stay FETCH. Zero-wait memory sustains 1 instr/cycle.
  - ack & !buf_free: skid<={rdata, pc+4, 1}; pc<=pc+4; go FULL.
  - no ack & buf_free: buf.valid<=0 (bubble).
- State FULL: imem_req=0. When hazard=0: buf<=skid; skid.valid<=0; go FETCH.
- State DRAIN: imem_req=1, imem_addr=drain_addr. On ack, data is discarded and state goes to FETCH. The new pc is unchanged.
- Redirect has priority over hazard and over ack capture. At the redirect edge:
  - pc<={redirect_pc[31:2],2'b00}; buf.valid<=0; skid.valid<=0.
  - From FETCH without same-cycle ack: drain_addr<=pc; go DRAIN.
  - From FETCH with same-cycle ack: data discarded; stay FETCH.
  - From FULL: go FETCH.
  - In DRAIN: pc updated; stay DRAIN; drain_addr unchanged.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0. No exception is raised.
- hazard alone never changes pc except by ack capture into skid. No instruction is lost, duplicated, or reordered.
- At most one outstanding memory request at any time.

Test Plan:
- Reset with zero-wait memory (ack tied to req) -> imem_addr 0,4,8,C on consecutive cycles; IF_newPC 4,8,C,10 one cycle later; IF_valid=1 continuously.
- hazard=1 for 3 cycles while buf holds addr 4, zero-wait -> outputs held (IF_newPC=8); addr 8 captured in skid; imem_req=0 for the remaining stall cycles. After release, IF_newPC sequence is 8,C,10 with no gap or duplicate.
- 2-wait-state memory (ack 2 cycles after req) -> imem_addr stable for 3 cycles; IF_valid=0 / IF_instr=NOP during waits; one instruction per 3 cycles.
- redirect to 0x100 while fetch of 0x8 awaits ack (2 cycles later) -> buffered instr flushed to NOP at the redirect edge; imem_addr holds 0x8 until ack; that data never appears; next imem_addr=0x100; then IF_newPC=0x104.
- redirect to 0x200 with hazard=1 and skid full -> buf and skid invalidated; state FETCH; next imem_addr=0x200; IF_valid=0 until the 0x200 ack.
- redirect to 0xFFFF_FFFE -> imem_addr=0xFFFF_FFFC; IF_newPC=0; next imem_addr=0. Async reset asserted mid-wait -> imem_req and outputs go to reset values before the next clock edge.
